// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// IF/ID update selectors, the default bubble word and small PC helpers.
package fetch_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Selects what the IF/ID register captures on the next rising edge
  localparam logic [1:0] IFID_KEEP   = 2'd0;
  localparam logic [1:0] IFID_BUBBLE = 2'd1;
  localparam logic [1:0] IFID_MEM    = 2'd2;
  localparam logic [1:0] IFID_BUF    = 2'd3;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0000;

  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential increment; natural 32-bit overflow gives the required wrap
  function automatic logic [31:0] pc_inc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding buffer for a fetched {instruction, next-PC} pair that
// arrived while decode was stalled.
module fetch_buf (
  input  logic        clk,
  input  logic        clear,
  input  logic        load,
  input  logic [63:0] load_data,
  output logic [63:0] data,
  output logic        valid
);

  // Clear wins over load so a redirect always discards a pending entry
  always_ff @(posedge clk) begin
    if (clear) begin
      data  <= 64'd0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues IMEM requests, tolerates arbitrary
// ACK latency, and feeds the IF/ID register with stall, flush and redirect handling.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = FETCH_NOP
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EX_MEM_PCSrc,
  input  logic [31:0] EX_MEM_NPC,
  input  logic        ID_STALL,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_INSTR,
  output logic [31:0] IF_ID_NPC,
  output logic        IF_ID_VALID
);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] addr_q;
  logic [31:0] pc_plus4;
  logic [1:0]  ifid_op;
  logic        buf_load;
  logic        buf_clear;
  logic [63:0] buf_data;
  logic        buf_valid;

  assign pc_plus4 = pc_inc(pc_q);

  fetch_buf u_buf (
    .clk       (CLK),
    .clear     (RST | buf_clear),
    .load      (buf_load),
    .load_data ({IMEM_RDATA, pc_plus4}),
    .data      (buf_data),
    .valid     (buf_valid)
  );

  // Next-state, PC and IF/ID selection; a redirect overrides everything else
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    ifid_op    = IFID_KEEP;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    if (EX_MEM_PCSrc) begin
      pc_next   = pc_align(EX_MEM_NPC);
      ifid_op   = IFID_BUBBLE;
      buf_clear = 1'b1;
      case (state)
        ST_REQ:   state_next = IMEM_ACK ? ST_REQ : ST_DRAIN;
        ST_DRAIN: state_next = ST_DRAIN;
        default:  state_next = ST_REQ;
      endcase
    end else begin
      case (state)
        ST_BOOT: begin
          state_next = ST_REQ;
          if (!ID_STALL) ifid_op = IFID_BUBBLE;
        end
        ST_REQ: begin
          if (IMEM_ACK) begin
            pc_next = pc_plus4;
            if (ID_STALL) begin
              buf_load   = 1'b1;
              state_next = ST_HOLD;
            end else begin
              ifid_op = IFID_MEM;
            end
          end else if (!ID_STALL) begin
            ifid_op = IFID_BUBBLE;
          end
        end
        ST_DRAIN: begin
          // The returning word belongs to the abandoned path and is dropped
          if (IMEM_ACK) state_next = ST_REQ;
          if (!ID_STALL) ifid_op = IFID_BUBBLE;
        end
        default: begin
          if (!ID_STALL) begin
            ifid_op    = IFID_BUF;
            buf_clear  = 1'b1;
            state_next = ST_REQ;
          end
        end
      endcase
    end
  end

  // DRAIN must keep presenting the old address until memory answers it
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_BOOT;
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      if (state_next != ST_DRAIN) addr_q <= pc_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      IF_ID_INSTR <= NOP_INSTR;
      IF_ID_NPC   <= 32'd0;
      IF_ID_VALID <= 1'b0;
    end else begin
      case (ifid_op)
        IFID_BUBBLE: begin
          IF_ID_INSTR <= NOP_INSTR;
          IF_ID_NPC   <= 32'd0;
          IF_ID_VALID <= 1'b0;
        end
        IFID_MEM: begin
          IF_ID_INSTR <= IMEM_RDATA;
          IF_ID_NPC   <= pc_plus4;
          IF_ID_VALID <= 1'b1;
        end
        IFID_BUF: begin
          IF_ID_INSTR <= buf_data[63:32];
          IF_ID_NPC   <= buf_data[31:0];
          IF_ID_VALID <= buf_valid;
        end
        default: ;
      endcase
    end
  end

  assign IMEM_REQ  = (state == ST_REQ) || (state == ST_DRAIN);
  assign IMEM_ADDR = addr_q;
  assign PC        = pc_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, is the instruction word driven into IF/ID on bubble or flush.
REQ-003 CLK  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 RST  input  1  is the reset; it is synchronous and active-high.
REQ-005 EX_MEM_PCSrc  input  1  is the branch/jump redirect request from the EX/MEM stage.
REQ-006 EX_MEM_NPC  input  32  is the redirect target; bits [1:0] are ignored and treated as 00.
REQ-007 ID_STALL  input  1  is the decode-stage hold request (e.g. load-use hazard).
REQ-008 IMEM_ACK  input  1  indicates that IMEM_RDATA is valid for the current request in this cycle.
REQ-009 IMEM_RDATA  input  32  is the instruction word returned by instruction memory.
REQ-010 IMEM_REQ  output  1  is the fetch request to instruction memory.
REQ-011 IMEM_ADDR  output  32  is the fetch address; it is registered.
REQ-012 PC  output  32  is the architectural fetch PC.
REQ-013 IF_ID_INSTR  output  32  is the IF/ID pipeline register instruction.
REQ-014 IF_ID_NPC  output  32  is the IF/ID pipeline register next-PC (fetch address + 4).
REQ-015 IF_ID_VALID  output  1  is 1 when the IF/ID register holds a real instruction and 0 when it holds a bubble.

Function
REQ-016 The state machine SHALL have four states: BOOT, REQ, DRAIN and HOLD.
REQ-017 BOOT SHALL drive IMEM_REQ=0 and SHALL move to REQ unconditionally after one cycle.
REQ-018 In REQ, IMEM_REQ SHALL be 1, IMEM_ADDR SHALL equal PC, and both SHALL be held stable until IMEM_ACK.
REQ-019 IMEM_ACK may arrive in the same cycle as the request or any number of cycles later; no timeout applies.
REQ-020 REQ with ACK, no redirect and ID_STALL=0: IF_ID SHALL load {RDATA, PC+4, VALID=1}, PC SHALL become PC+4, and the state SHALL stay REQ.
REQ-021 REQ with ACK, no redirect and ID_STALL=1: {RDATA, PC+4} SHALL go into the holding buffer, PC SHALL become PC+4, IF_ID SHALL hold, and the state SHALL move to HOLD.
REQ-022 REQ with no ACK and ID_STALL=0: IF_ID SHALL load a bubble {NOP_INSTR, 0, VALID=0}.
REQ-023 REQ with no ACK and ID_STALL=1: IF_ID SHALL hold.
REQ-024 In HOLD, IMEM_REQ SHALL be 0; when ID_STALL=0, IF_ID SHALL load the buffer with VALID=1 and the state SHALL move to REQ.
REQ-025 EX_MEM_PCSrc=1 SHALL have highest priority: PC becomes {EX_MEM_NPC[31:2],2'b00}, IF_ID is flushed to a bubble regardless of ID_STALL, and the buffer is discarded.
REQ-026 A redirect in REQ with ACK in the same cycle SHALL discard RDATA; the next state SHALL be REQ at the new PC.
REQ-027 A redirect in REQ without ACK SHALL keep IMEM_REQ=1 with the old IMEM_ADDR and SHALL move to DRAIN.
REQ-028 DRAIN SHALL keep the request asserted, discard RDATA on ACK, and then move to REQ at the current PC.
REQ-029 A redirect in DRAIN SHALL update PC only and SHALL stay in DRAIN.
REQ-030 A redirect in HOLD or BOOT SHALL move to REQ at the new PC.
REQ-031 PC+4 SHALL wrap modulo 2^32; 32'hFFFF_FFFC + 4 gives 32'h0000_0000.

Reset
REQ-032 RST=1 SHALL set state=BOOT, PC=RESET_PC, IMEM_REQ=0, IMEM_ADDR=RESET_PC, IF_ID_INSTR=NOP_INSTR, IF_ID_NPC=0, IF_ID_VALID=0, and clear the buffer.
REQ-033 RST SHALL override all other inputs, including mid-request and in DRAIN; instruction memory is reset by the same RST, so an outstanding request is abandoned.

Structure
REQ-034 The state encoding and the default NOP_INSTR constant SHALL reside in shared package fetch_pkg.
REQ-035 The one-entry holding buffer SHALL be a sub-module named fetch_buf, with load, clear and 64-bit data ports.

Verification
REQ-036 Scenario: reset, then ACK every cycle with RDATA=addr -> IF_ID_NPC sequence 4, 8, 12, all with VALID=1, and first IMEM_REQ one cycle after BOOT.
REQ-037 Scenario: ACK two cycles late -> IMEM_ADDR held stable, two bubbles (VALID=0, INSTR=NOP_INSTR) before the instruction enters IF_ID.
REQ-038 Scenario: ID_STALL=1 coincident with ACK at PC=0x10 -> HOLD with IMEM_REQ=0; after stall release, IF_ID={RDATA, 0x14}; next request goes to 0x14.
REQ-039 Scenario: redirect to 0x103 while a request at 0x20 is pending -> DRAIN, ack at 0x20 discarded, next IMEM_ADDR=0x100, and no valid instruction from 0x20.
REQ-040 Scenario: redirect with same-cycle ACK and ID_STALL=1 -> IF_ID flushed (VALID=0), next IMEM_ADDR equals the target.
REQ-041 Scenario: RST asserted in DRAIN -> next cycle all outputs at reset values; PC=0xFFFF_FFFC with ACK -> PC wraps to 0.
